cprv_wb_unit: RTL and testbench

Parametrised write-back stage for the cprv pipeline, successor to the fixed-width OP/LOAD-only write-back.
- Holds one retiring instruction in a pipeline register with a valid/ready handshake toward the mem stage.
- Builds the full RV32I/RV64I destination value: load align and extend, word-op sign extension, link address, LUI.
- Drives an external regfile write port, a forwarding port for the decode/execute bypass, and a retired-instruction counter.

---
 rtl/cprv_pkg.sv | 38 +++
 rtl/cprv_load_align.sv | 48 ++++
 rtl/cprv_wb_unit.sv | 143 ++++++++++++++
 tb/tb_cprv_wb_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cprv_pkg.sv
// ============================================================================
// cprv_pkg : shared opcodes, load funct3 encodings and wb entry fields
// Rev 1.0
// ============================================================================
`default_nettype none

package cprv_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_addr;
    logic       rd_en;
  } wb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cprv_load_align.sv
// ============================================================================
// cprv_load_align : extracts and extends a load value from an aligned word
// Rev 1.0
// ============================================================================
`default_nettype none

module cprv_load_align
  import cprv_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [OFF_W-1:0]      offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  // Misaligned low bits are dropped so halfwords and words stay naturally aligned.
  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      word_sel;

  assign off_h    = offset & ~OFF_W'(1);
  assign off_w    = offset & ~OFF_W'(3);
  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{off_h, 3'b000} +: 16];
  assign word_sel = rdata[{off_w, 3'b000} +: 32];

  always_comb begin
    data = '0;
    case (funct3)
      LB:  data = DATA_WIDTH'($signed(byte_sel));
      LH:  data = DATA_WIDTH'($signed(half_sel));
      LW:  data = DATA_WIDTH'($signed(word_sel));
      LBU: data = DATA_WIDTH'(byte_sel);
      LHU: data = DATA_WIDTH'(half_sel);
      LD:  if (DATA_WIDTH == 64) data = rdata;
      LWU: if (DATA_WIDTH == 64) data = DATA_WIDTH'(word_sel);
      default: data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cprv_wb_unit.sv
// ============================================================================
// cprv_wb_unit : write-back stage holding one retiring instruction
// Rev 1.0
// ============================================================================
`default_nettype none

module cprv_wb_unit
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IMM_WIDTH  = 32,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_wb_i,
  output logic                  ready_wb_o,
  input  logic [6:0]            opcode_wb_i,
  input  logic [2:0]            funct3_wb_i,
  input  logic [4:0]            rd_addr_wb_i,
  input  logic                  rd_en_wb_i,
  input  logic [IMM_WIDTH-1:0]  imm_data_wb_i,
  input  logic [PC_WIDTH-1:0]   pc_wb_i,
  input  logic [DATA_WIDTH-1:0] alu_out_wb_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_wb_i,
  input  logic                  stall_wb_i,
  output logic                  rd_we_o,
  output logic [4:0]            rd_waddr_o,
  output logic [DATA_WIDTH-1:0] rd_wdata_o,
  output logic                  fwd_valid_o,
  output logic [4:0]            fwd_addr_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  logic                  full;
  wb_ctrl_t              ctrl;
  logic [IMM_WIDTH-1:0]  imm;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] alu;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CNT_WIDTH-1:0]  instret;

  logic                  accept;
  logic                  retire;
  logic                  legal;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] load_data;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic                  writes_rd;

  assign ready_wb_o = ~full | ~stall_wb_i;
  assign accept     = valid_wb_i & ready_wb_o;
  assign retire     = full & ~stall_wb_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      ctrl    <= '0;
      imm     <= '0;
      pc      <= '0;
      alu     <= '0;
      rdata   <= '0;
      instret <= '0;
    end else begin
      if (accept) begin
        full   <= 1'b1;
        ctrl   <= '{opcode: opcode_wb_i, funct3: funct3_wb_i,
                    rd_addr: rd_addr_wb_i, rd_en: rd_en_wb_i};
        imm    <= imm_data_wb_i;
        pc     <= pc_wb_i;
        alu    <= alu_out_wb_i;
        rdata  <= mem_rdata_wb_i;
      end else if (retire) begin
        full   <= 1'b0;
      end
      if (retire) instret <= instret + CNT_WIDTH'(1);
    end
  end

  cprv_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .rdata  (rdata),
    .offset (alu[OFF_W-1:0]),
    .funct3 (ctrl.funct3),
    .data   (load_data)
  );

  assign pc_plus4 = pc + PC_WIDTH'(4);

  always_comb begin
    legal  = 1'b0;
    result = '0;
    case (ctrl.opcode)
      OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
        legal  = 1'b1;
        result = alu;
      end
      OPC_OP_32, OPC_OP_IMM_32: begin
        if (DATA_WIDTH == 64) begin
          legal  = 1'b1;
          result = DATA_WIDTH'($signed(alu[31:0]));
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        result = DATA_WIDTH'($signed(imm));
      end
      OPC_JAL, OPC_JALR: begin
        legal  = 1'b1;
        result = DATA_WIDTH'(pc_plus4);
      end
      OPC_LOAD: begin
        case (ctrl.funct3)
          LB, LH, LW, LBU, LHU: legal = 1'b1;
          LD, LWU:              legal = (DATA_WIDTH == 64);
          default:              legal = 1'b0;
        endcase
        result = legal ? load_data : '0;
      end
      default: begin
        legal  = 1'b0;
        result = '0;
      end
    endcase
  end

  assign writes_rd   = full & ctrl.rd_en & (ctrl.rd_addr != 5'd0) & legal;
  assign rd_we_o     = writes_rd & ~stall_wb_i;
  assign rd_waddr_o  = ctrl.rd_addr;
  assign rd_wdata_o  = result;
  assign fwd_valid_o = writes_rd;
  assign fwd_addr_o  = ctrl.rd_addr;
  assign fwd_data_o  = result;
  assign instret_o   = instret;

endmodule

`default_nettype wire

// File: tb/tb_cprv_wb_unit.sv
// ============================================================================
// tb_cprv_wb_unit : directed vector bench for the cprv write-back stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cprv_wb_unit;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP32   = 7'b0111011;
  localparam logic [6:0] T_OPI32  = 7'b0011011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_wb_i = 1'b0;
  logic        ready_wb_o;
  logic [6:0]  opcode_wb_i = '0;
  logic [2:0]  funct3_wb_i = '0;
  logic [4:0]  rd_addr_wb_i = '0;
  logic        rd_en_wb_i = 1'b0;
  logic [31:0] imm_data_wb_i = '0;
  logic [63:0] pc_wb_i = '0;
  logic [63:0] alu_out_wb_i = '0;
  logic [63:0] mem_rdata_wb_i = '0;
  logic        stall_wb_i = 1'b0;
  logic        rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [63:0] rd_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [63:0] fwd_data_o;
  logic [63:0] instret_o;

  cprv_wb_unit #(
    .DATA_WIDTH (64),
    .IMM_WIDTH  (32),
    .PC_WIDTH   (64),
    .CNT_WIDTH  (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_wb_i     (valid_wb_i),
    .ready_wb_o     (ready_wb_o),
    .opcode_wb_i    (opcode_wb_i),
    .funct3_wb_i    (funct3_wb_i),
    .rd_addr_wb_i   (rd_addr_wb_i),
    .rd_en_wb_i     (rd_en_wb_i),
    .imm_data_wb_i  (imm_data_wb_i),
    .pc_wb_i        (pc_wb_i),
    .alu_out_wb_i   (alu_out_wb_i),
    .mem_rdata_wb_i (mem_rdata_wb_i),
    .stall_wb_i     (stall_wb_i),
    .rd_we_o        (rd_we_o),
    .rd_waddr_o     (rd_waddr_o),
    .rd_wdata_o     (rd_wdata_o),
    .fwd_valid_o    (fwd_valid_o),
    .fwd_addr_o     (fwd_addr_o),
    .fwd_data_o     (fwd_data_o),
    .instret_o      (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] imm;
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic        we;
    logic [63:0] data;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [63:0] exp_cnt = '0;

  // Writes are counted where the write enable is stable, one half cycle before the edge.
  always @(negedge clk) if (rd_we_o) wr_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [4:0] rd, input logic rd_en, input logic [31:0] imm,
                     input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] rdata,
                     input logic we, input logic [63:0] data);
    vec_t v;
    v = '{name, opc, f3, rd, rd_en, imm, pc, alu, rdata, we, data};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    valid_wb_i     = 1'b1;
    opcode_wb_i    = v.opc;
    funct3_wb_i    = v.f3;
    rd_addr_wb_i   = v.rd;
    rd_en_wb_i     = v.rd_en;
    imm_data_wb_i  = v.imm;
    pc_wb_i        = v.pc;
    alu_out_wb_i   = v.alu;
    mem_rdata_wb_i = v.rdata;
  endtask

  initial begin
    vec_t v;
    int   wr0;

    add("op",      T_OP,    3'd0, 5'd5,  1'b1, 32'h0, 64'h0, 64'h1234, 64'h0, 1'b1, 64'h1234);
    add("lb",      T_LOAD,  3'd0, 5'd6,  1'b1, 32'h0, 64'h0, 64'h103, 64'h00000000_80000000, 1'b1, 64'hFFFFFFFF_FFFFFF80);
    add("lbu",     T_LOAD,  3'd4, 5'd6,  1'b1, 32'h0, 64'h0, 64'h103, 64'h00000000_80000000, 1'b1, 64'h80);
    add("lhu",     T_LOAD,  3'd5, 5'd7,  1'b1, 32'h0, 64'h0, 64'h206, 64'hBEEF0000_00000000, 1'b1, 64'hBEEF);
    add("op32",    T_OP32,  3'd0, 5'd8,  1'b1, 32'h0, 64'h0, 64'h00000000_80000001, 64'h0, 1'b1, 64'hFFFFFFFF_80000001);
    add("opimm32", T_OPI32, 3'd0, 5'd8,  1'b1, 32'h0, 64'h0, 64'hFFFFFFFF_7FFFFFFF, 64'h0, 1'b1, 64'h7FFFFFFF);
    add("jal",     T_JAL,   3'd0, 5'd1,  1'b1, 32'h0, 64'h1000, 64'h0, 64'h0, 1'b1, 64'h1004);
    add("jalr_wr", T_JALR,  3'd0, 5'd1,  1'b1, 32'h0, 64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'h0, 1'b1, 64'h0);
    add("lui",     T_LUI,   3'd0, 5'd9,  1'b1, 32'h80000000, 64'h0, 64'h0, 64'h0, 1'b1, 64'hFFFFFFFF_80000000);
    add("auipc",   T_AUIPC, 3'd0, 5'd10, 1'b1, 32'h0, 64'h0, 64'hDEAD, 64'h0, 1'b1, 64'hDEAD);
    add("lw_mis",  T_LOAD,  3'd2, 5'd11, 1'b1, 32'h0, 64'h0, 64'h5, 64'h87654321_00000000, 1'b1, 64'hFFFFFFFF_87654321);
    add("lwu",     T_LOAD,  3'd6, 5'd11, 1'b1, 32'h0, 64'h0, 64'h5, 64'h87654321_00000000, 1'b1, 64'h87654321);
    add("lh_mis",  T_LOAD,  3'd1, 5'd12, 1'b1, 32'h0, 64'h0, 64'h3, 64'h00000000_F00D0000, 1'b1, 64'hFFFFFFFF_FFFFF00D);
    add("ld",      T_LOAD,  3'd3, 5'd13, 1'b1, 32'h0, 64'h0, 64'h0, 64'h01234567_89ABCDEF, 1'b1, 64'h01234567_89ABCDEF);
    add("ld_f7",   T_LOAD,  3'd7, 5'd13, 1'b1, 32'h0, 64'h0, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 64'h0);
    add("illegal", T_SYSTEM,3'd0, 5'd14, 1'b1, 32'h0, 64'h0, 64'h55, 64'h0, 1'b0, 64'h0);
    add("rd_x0",   T_OP,    3'd0, 5'd0,  1'b1, 32'h0, 64'h0, 64'h77, 64'h0, 1'b0, 64'h77);
    add("no_rden", T_OP,    3'd0, 5'd15, 1'b0, 32'h0, 64'h0, 64'h88, 64'h0, 1'b0, 64'h88);

    // Reset state before any clock edge.
    #2;
    check("rst_ready",   ready_wb_o,  64'd1);
    check("rst_we",      rd_we_o,     64'd0);
    check("rst_fwd",     fwd_valid_o, 64'd0);
    check("rst_instret", instret_o,   64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1 drive(vecs[i]);
      @(posedge clk); #1 valid_wb_i = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_we"},      rd_we_o,     64'(vecs[i].we));
      check({vecs[i].name, "_fwd"},     fwd_valid_o, 64'(vecs[i].we));
      check({vecs[i].name, "_wdata"},   rd_wdata_o,  vecs[i].data);
      check({vecs[i].name, "_fdata"},   fwd_data_o,  vecs[i].data);
      check({vecs[i].name, "_waddr"},   64'(rd_waddr_o), 64'(vecs[i].rd));
      check({vecs[i].name, "_instret"}, instret_o,   exp_cnt);
      exp_cnt++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("table_instret", instret_o, exp_cnt);
    check("table_empty_we", rd_we_o, 64'd0);

    // Asynchronous reset while an entry is held.
    v = vecs[0];
    @(posedge clk); #1 drive(v);
    @(posedge clk); #1 valid_wb_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we",      rd_we_o,     64'd0);
    check("midrst_fwd",     fwd_valid_o, 64'd0);
    check("midrst_instret", instret_o,   64'd0);
    check("midrst_ready",   ready_wb_o,  64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    check("midrst_after_we", rd_we_o, 64'd0);

    // Stall holds the entry for three cycles, then exactly one write.
    v = vecs[0];
    v.rd  = 5'd7;
    v.alu = 64'h55;
    wr0 = wr_cnt;
    @(posedge clk); #1 drive(v);
    @(posedge clk); #1 begin valid_wb_i = 1'b0; stall_wb_i = 1'b1; end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_ready",   ready_wb_o,  64'd0);
      check("stall_we",      rd_we_o,     64'd0);
      check("stall_fwd",     fwd_valid_o, 64'd1);
      check("stall_fdata",   fwd_data_o,  64'h55);
      check("stall_faddr",   64'(fwd_addr_o), 64'd7);
      check("stall_instret", instret_o,   exp_cnt);
    end
    @(posedge clk); #1 stall_wb_i = 1'b0;
    @(negedge clk);
    check("unstall_we", rd_we_o, 64'd1);
    exp_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    check("unstall_instret", instret_o, exp_cnt);
    check("unstall_writes",  64'(wr_cnt - wr0), 64'd1);
    check("unstall_we_off",  rd_we_o, 64'd0);

    // Four back-to-back instructions, the second targeting x0.
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      v = vecs[0];
      v.rd  = (k == 1) ? 5'd0 : 5'(k + 2);
      v.alu = 64'(k + 100);
      @(posedge clk); #1 drive(v);
      #2 check("b2b_ready", ready_wb_o, 64'd1);
    end
    @(posedge clk); #1 valid_wb_i = 1'b0;
    @(negedge clk);
    check("b2b_last_data", rd_wdata_o, 64'd103);
    check("b2b_last_addr", 64'(rd_waddr_o), 64'd5);
    check("b2b_ready_end", ready_wb_o, 64'd1);
    exp_cnt += 4;
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_instret", instret_o, exp_cnt);
    check("b2b_writes",  64'(wr_cnt - wr0), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
